// File: rtl/if_id_stage_if.sv
// Signal bundle between the IF stage and its neighbours: hazard unit, instruction memory and ID.
// Handshake: a fetch is accepted on a rising edge where imem_req_o && imem_ready_i.
// imem_ready_i may be high when imem_req_o is low; that word is then ignored.
interface if_id_stage_if #(
    parameter int CNT_W = 16
);
    logic             stall_i;
    logic             branch_i;
    logic [31:0]      branch_target_i;
    logic [31:0]      imem_addr_o;
    logic             imem_req_o;
    logic             imem_ready_i;
    logic [31:0]      imem_data_i;
    logic             if_id_valid_o;
    logic [31:0]      if_id_pc4_o;
    logic [31:0]      if_id_instr_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    // Environment side: hazard unit, instruction memory and ID consumer.
    modport master (
        output stall_i, branch_i, branch_target_i, imem_ready_i, imem_data_i,
        input  imem_addr_o, imem_req_o, if_id_valid_o, if_id_pc4_o, if_id_instr_o,
        input  stall_cnt_o, flush_cnt_o
    );

    // The fetch stage itself.
    modport slave (
        input  stall_i, branch_i, branch_target_i, imem_ready_i, imem_data_i,
        output imem_addr_o, imem_req_o, if_id_valid_o, if_id_pc4_o, if_id_instr_o,
        output stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/if_id_stage.sv
// Instruction-fetch stage: owns the PC, fetches from imem and fills the IF/ID register.
// Obeys hazard-unit stall/branch and keeps saturating stall/flush counters.
module if_id_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic          clk_i,
    input  logic          rst_n,
    if_id_stage_if.slave  bus
);
    localparam logic [31:0]      PC_INIT = {PC_RESET[31:2], 2'b00};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             ifid_valid;
    logic [31:0]      ifid_pc4;
    logic [31:0]      ifid_instr;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Wraps modulo 2^32 by construction.
    assign pc_plus4 = pc + 32'd4;

    // Priority: branch, then stall, then miss, then fetch.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= PC_INIT;
            ifid_valid <= 1'b0;
            ifid_pc4   <= 32'h0;
            ifid_instr <= 32'h0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else if (bus.branch_i) begin
            pc         <= {bus.branch_target_i[31:2], 2'b00};
            ifid_valid <= 1'b0;
            ifid_pc4   <= 32'h0;
            ifid_instr <= 32'h0;
            if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
        end else if (bus.stall_i) begin
            if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
        end else if (!bus.imem_ready_i) begin
            ifid_valid <= 1'b0;
            ifid_pc4   <= 32'h0;
            ifid_instr <= 32'h0;
        end else begin
            pc         <= pc_plus4;
            ifid_valid <= 1'b1;
            ifid_pc4   <= pc_plus4;
            ifid_instr <= bus.imem_data_i;
        end
    end

    // Redirects appear one cycle after branch_i since the address comes only from the PC register.
    assign bus.imem_addr_o   = pc;
    assign bus.imem_req_o    = rst_n & ~bus.stall_i & ~bus.branch_i;
    assign bus.if_id_valid_o = ifid_valid;
    assign bus.if_id_pc4_o   = ifid_pc4;
    assign bus.if_id_instr_o = ifid_instr;
    assign bus.stall_cnt_o   = stall_cnt;
    assign bus.flush_cnt_o   = flush_cnt;
endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a 16-bit-counter instance plus a 4-bit-counter twin
// that sees identical stimulus so counter saturation can be observed.
module tb_if_id_stage;
    logic clk_i;
    logic rst_n;
    int   total;
    int   bad;

    if_id_stage_if #(.CNT_W(16)) bus  ();
    if_id_stage_if #(.CNT_W(4))  bus4 ();

    if_id_stage #(.PC_RESET(32'h0), .CNT_W(16)) dut  (.clk_i(clk_i), .rst_n(rst_n), .bus(bus));
    if_id_stage #(.PC_RESET(32'h0), .CNT_W(4))  dut4 (.clk_i(clk_i), .rst_n(rst_n), .bus(bus4));

    assign bus4.stall_i         = bus.stall_i;
    assign bus4.branch_i        = bus.branch_i;
    assign bus4.branch_target_i = bus.branch_target_i;
    assign bus4.imem_ready_i    = bus.imem_ready_i;
    assign bus4.imem_data_i     = bus.imem_data_i;

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_ifid(input string name, input logic v, input logic [31:0] pc4,
                              input logic [31:0] instr, input logic [31:0] addr);
        total++;
        if (bus.if_id_valid_o !== v || bus.if_id_pc4_o !== pc4 ||
            bus.if_id_instr_o !== instr || bus.imem_addr_o !== addr) begin
            bad++;
            $display("FAIL %s: got v=%b pc4=%h instr=%h addr=%h, want v=%b pc4=%h instr=%h addr=%h",
                     name, bus.if_id_valid_o, bus.if_id_pc4_o, bus.if_id_instr_o, bus.imem_addr_o,
                     v, pc4, instr, addr);
        end
    endtask

    task automatic check_cnt(input string name, input logic [15:0] sc, input logic [15:0] fc);
        total++;
        if (bus.stall_cnt_o !== sc || bus.flush_cnt_o !== fc) begin
            bad++;
            $display("FAIL %s: got stall_cnt=%0d flush_cnt=%0d, want %0d %0d",
                     name, bus.stall_cnt_o, bus.flush_cnt_o, sc, fc);
        end
    endtask

    task automatic check_req(input string name, input logic want);
        total++;
        if (bus.imem_req_o !== want) begin
            bad++;
            $display("FAIL %s: got imem_req=%b want %b", name, bus.imem_req_o, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.stall_i = 1'b0;
        bus.branch_i = 1'b0;
        bus.branch_target_i = 32'h0;
        bus.imem_ready_i = 1'b1;
        bus.imem_data_i = 32'h0;
        #2;
        check_ifid("reset_ifid", 1'b0, 32'h0, 32'h0, 32'h0);
        check_cnt("reset_cnt", 16'd0, 16'd0);
        check_req("reset_req", 1'b0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check_req("reset_release_req", 1'b1);
    endtask

    task automatic test_fetch();
        bus.imem_ready_i = 1'b1;
        bus.imem_data_i = 32'h11;
        step();
        check_ifid("fetch_0x11", 1'b1, 32'd4, 32'h11, 32'd4);
        bus.imem_data_i = 32'h22;
        step();
        check_ifid("fetch_0x22", 1'b1, 32'd8, 32'h22, 32'd8);
    endtask

    task automatic test_stall();
        bus.stall_i = 1'b1;
        bus.imem_data_i = 32'hDEAD_BEEF;
        #1;
        check_req("stall_req", 1'b0);
        for (int i = 1; i <= 2; i++) begin
            step();
            check_ifid("stall_hold", 1'b1, 32'd8, 32'h22, 32'd8);
            check_cnt("stall_cnt", 16'(i), 16'd0);
        end
        bus.stall_i = 1'b0;
        bus.imem_data_i = 32'h33;
        step();
        check_ifid("fetch_0x33", 1'b1, 32'd12, 32'h33, 32'd12);
    endtask

    task automatic test_branch();
        bus.branch_i = 1'b1;
        bus.stall_i = 1'b1;
        bus.branch_target_i = 32'h103;
        #1;
        check_req("branch_req", 1'b0);
        step();
        check_ifid("branch_bubble", 1'b0, 32'h0, 32'h0, 32'h100);
        check_cnt("branch_cnt", 16'd2, 16'd1);
        bus.branch_i = 1'b0;
        bus.stall_i = 1'b0;
        bus.imem_data_i = 32'h44;
        step();
        check_ifid("branch_target_fetch", 1'b1, 32'h104, 32'h44, 32'h104);
    endtask

    task automatic test_miss();
        bus.imem_ready_i = 1'b0;
        bus.imem_data_i = 32'hBAD0_0000;
        #1;
        check_req("miss_req", 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_ifid("miss_bubble", 1'b0, 32'h0, 32'h0, 32'h104);
        end
        check_cnt("miss_cnt", 16'd2, 16'd1);
    endtask

    task automatic test_wrap();
        bus.branch_i = 1'b1;
        bus.branch_target_i = 32'hFFFF_FFFE;
        step();
        check_ifid("wrap_branch", 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        check_cnt("wrap_flush_cnt", 16'd2, 16'd2);
        bus.branch_i = 1'b0;
        bus.imem_ready_i = 1'b1;
        bus.imem_data_i = 32'h55;
        step();
        check_ifid("wrap_fetch", 1'b1, 32'h0, 32'h55, 32'h0);
    endtask

    task automatic test_saturation();
        logic [3:0] exp4;
        bus.stall_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            exp4 = (2 + i > 15) ? 4'hF : 4'(2 + i);
            total++;
            if (bus4.stall_cnt_o !== exp4) begin
                bad++;
                $display("FAIL sat_cnt4 cycle %0d: got %h want %h", i, bus4.stall_cnt_o, exp4);
            end
        end
        check_cnt("sat_cnt16", 16'd22, 16'd2);
        check_ifid("sat_hold", 1'b1, 32'h0, 32'h55, 32'h0);
        bus.stall_i = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.branch_i = 1'b1;
        bus.stall_i = 1'b1;
        bus.branch_target_i = 32'h200;
        #3;
        rst_n = 1'b0;
        #1;
        check_ifid("async_reset_ifid", 1'b0, 32'h0, 32'h0, 32'h0);
        check_cnt("async_reset_cnt", 16'd0, 16'd0);
        check_req("async_reset_req", 1'b0);
        total++;
        if (bus4.stall_cnt_o !== 4'h0) begin
            bad++;
            $display("FAIL async_reset_cnt4: got %h want 0", bus4.stall_cnt_o);
        end
        step();
        check_ifid("reset_discard_branch", 1'b0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        bus.branch_i = 1'b0;
        bus.stall_i = 1'b0;
        bus.imem_ready_i = 1'b1;
        bus.imem_data_i = 32'h66;
        step();
        check_ifid("post_reset_fetch", 1'b1, 32'd4, 32'h66, 32'd4);
        check_cnt("post_reset_cnt", 16'd0, 16'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_fetch();
        test_stall();
        test_branch();
        test_miss();
        test_wrap();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS core, directly upstream of the hazard-detection unit. It owns the program counter, issues fetch addresses to instruction memory, and captures fetched instructions into the IF/ID register. It obeys the hazard unit's stall (freeze) and branch (redirect plus flush) outputs. It also keeps saturating stall and flush counters for performance debugging.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk_i  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  load-use stall from the hazard unit; freezes PC and IF/ID.
- branch_i  in  1  taken branch resolved in ID; redirect and flush.
- branch_target_i  in  32  branch destination; bits [1:0] ignored and treated as 00.
- imem_addr_o  out  32  fetch address; always equals the PC register.
- imem_req_o  out  1  fetch request; equals rst_n & ~stall_i & ~branch_i.
- imem_ready_i  in  1  imem_data_i is valid for imem_addr_o this cycle.
- imem_data_i  in  32  fetched instruction word.
- if_id_valid_o  out  1  IF/ID holds a real instruction (0 means bubble).
- if_id_pc4_o  out  32  PC+4 of the instruction held in IF/ID.
- if_id_instr_o  out  32  instruction held in IF/ID; 32'h0 (nop) when it is a bubble.
- stall_cnt_o  out  CNT_W  number of cycles with an effective stall.
- flush_cnt_o  out  CNT_W  number of branch flushes.

## Operation
Each cycle exactly one case applies, in this priority order:
1. **Branch** (branch_i=1, regardless of stall_i or imem_ready_i):
   - PC <= {branch_target_i[31:2], 2'b00}.
   - IF/ID <= bubble (valid=0, pc4=0, instr=0).
   - flush_cnt increments.
2. **Stall** (stall_i=1, branch_i=0):
   - PC holds and IF/ID holds all fields.
   - stall_cnt increments.
   - imem_data_i is discarded.
3. **Miss** (imem_ready_i=0):
   - PC holds.
   - IF/ID <= bubble.
   - No counter changes.
4. **Fetch** (otherwise):
   - PC <= PC+4.
   - IF/ID <= {valid=1, pc4=PC+4, instr=imem_data_i}.

Arithmetic and width rules:
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000); there is no overflow flag.
- Both counters saturate at all-ones and never wrap.

Reset:
- Asserting rst_n low immediately, without waiting for a clock edge, sets PC=PC_RESET, IF/ID=bubble, and both counters=0.
- imem_req_o is 0 while rst_n=0.
- The first fetch edge is the first rising clk_i edge after rst_n deasserts.
- Reset asserted mid-stall or mid-branch discards that operation completely.

Fetch-address and request rules:
- imem_addr_o is driven from the PC register only, never from branch_target_i combinationally. The redirect therefore appears one cycle after branch_i.
- imem_req_o=0 during stall or branch cycles, so memory must not advance any side effects.

## Timing
- Fetch-to-IF/ID latency is 1 cycle: a word present with imem_ready_i=1 at edge N appears on if_id_* after edge N.
- Branch penalty:
  - Cycle N: branch_i=1.
  - After edge N: IF/ID holds a bubble and PC=target.
  - Edge N+1 fetches the target (if ready).
  - The target instruction reaches IF/ID after edge N+1.
- A stall held for k cycles freezes IF/ID for exactly k cycles and adds exactly k to stall_cnt.
- Stall and branch asserted in the same cycle: branch wins; stall_cnt does not change and flush_cnt increments.
- All outputs except imem_req_o are registered; imem_req_o is combinational from stall_i, branch_i and rst_n.

## Test plan
- **Reset:** rst_n=0 asserted asynchronously mid-cycle → PC=PC_RESET, if_id_valid_o=0, if_id_instr_o=0, counters=0 immediately; imem_req_o=0.
- **Sequential fetch:** imem_ready_i=1, words 0x11,0x22,0x33 from PC 0 → IF/ID shows (pc4=4,0x11), (8,0x22), (12,0x33) on consecutive cycles with valid=1.
- **Stall:** stall_i high for 2 cycles while IF/ID holds (pc4=8,0x22) → IF/ID and PC=8 unchanged for 2 cycles, stall_cnt_o=2, imem_req_o=0; fetch resumes at 8.
- **Branch:** branch_i=1 with target 0x103 and stall_i=1 in the same cycle → PC=0x100, IF/ID bubble, flush_cnt_o=1, stall_cnt_o unchanged; the next IF/ID pc4=0x104.
- **Miss and wrap:**
  - imem_ready_i=0 for 3 cycles → PC held, 3 bubbles.
  - Branch to 0xFFFF_FFFC, then fetch → pc4=0x0000_0000 and PC wraps to 0.
- **Saturation:** with CNT_W=4, 20 stall cycles → stall_cnt_o=4'hF and holds there.
